// File: rtl/mmcm_lock_seq.sv
// Power/reset sequencer for one MMCME2_BASE: holds reset, waits for a qualified lock, retries, flags faults.
// Optional macro MMCM_SEQ_PWRDWN_EN adds the i_pwrdn_req input and the PDN state.
module mmcm_lock_seq #(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 125000,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRY    = 4,
  parameter int CNT_W        = 17
) (
  input  logic       i_clkin,
  input  logic       i_rst_n,
  input  logic       i_locked_async,
  input  logic       i_restart,
`ifdef MMCM_SEQ_PWRDWN_EN
  input  logic       i_pwrdn_req,
`endif
  output logic       o_mmcm_rst,
  output logic       o_mmcm_pwrdwn,
  output logic       o_clk_ready,
  output logic       o_fault,
  output logic [2:0] o_retry_cnt,
  output logic [7:0] o_loss_cnt,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4,
    S_PDN    = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic             r_mmcm_rst;
  logic             r_clk_ready;
  logic             r_fault;
  logic [2:0]       r_retry;
  logic [7:0]       r_loss;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_fault_nxt;
  logic [2:0]       w_retry_nxt;
  logic [2:0]       w_retry_inc;
  logic [7:0]       w_loss_nxt;
  logic             w_pdn_req;
  logic             w_mmcm_rst_nxt;
  logic             w_clk_ready_nxt;

`ifdef MMCM_SEQ_PWRDWN_EN
  assign w_pdn_req = i_pwrdn_req;
`else
  assign w_pdn_req = 1'b0;
`endif

  // LOCKED comes from the generated clock domain; only the synchronised copy is ever used.
  always_ff @(posedge i_clkin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_locked_async;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    w_retry_inc = r_retry + 3'd1;
    if (w_pdn_req) begin
      w_state_nxt = S_PDN;
      w_cnt_nxt   = '0;
    end else if (i_restart) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_retry_nxt = 3'd0;
      w_fault_nxt = 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // A lock arriving on the timeout cycle wins over the timeout.
          if (r_lock_s) begin
            w_state_nxt = S_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            w_cnt_nxt   = '0;
            w_retry_nxt = w_retry_inc;
            if (w_retry_inc == 3'(MAX_RETRY)) begin
              w_state_nxt = S_FAULT;
              w_fault_nxt = 1'b1;
            end else begin
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(LOCK_STABLE - 1)) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_retry_nxt = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
            if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
          end
        end
        S_FAULT: begin
          w_cnt_nxt = '0;
        end
        S_PDN: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_retry_nxt = 3'd0;
          w_fault_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
      endcase
    end
    w_mmcm_rst_nxt  = (w_state_nxt == S_HOLD) || (w_state_nxt == S_FAULT) ||
                      (w_state_nxt == S_PDN);
    w_clk_ready_nxt = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge i_clkin or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_mmcm_rst  <= 1'b1;
      r_clk_ready <= 1'b0;
      r_fault     <= 1'b0;
      r_retry     <= 3'd0;
      r_loss      <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mmcm_rst  <= w_mmcm_rst_nxt;
      r_clk_ready <= w_clk_ready_nxt;
      r_fault     <= w_fault_nxt;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
    end
  end

`ifdef MMCM_SEQ_PWRDWN_EN
  logic r_pwrdwn;
  always_ff @(posedge i_clkin or negedge i_rst_n) begin
    if (!i_rst_n) r_pwrdwn <= 1'b0;
    else          r_pwrdwn <= (w_state_nxt == S_PDN);
  end
  assign o_mmcm_pwrdwn = r_pwrdwn;
`else
  assign o_mmcm_pwrdwn = 1'b0;
`endif

  assign o_mmcm_rst  = r_mmcm_rst;
  assign o_clk_ready = r_clk_ready;
  assign o_fault     = r_fault;
  assign o_retry_cnt = r_retry;
  assign o_loss_cnt  = r_loss;
  assign o_state     = r_state;

endmodule
